// File: rtl/abfn_tick_pkg.sv
// Shared types and defaults for the fabric timebase generator.
package abfn_tick_pkg;

  typedef enum logic [1:0] {
    StStop = 2'd0,
    StRun  = 2'd1,
    StLoad = 2'd2
  } tick_state_e;

  localparam int unsigned AccWDefault = 24;

  // Phase increment for a 16x oversample strobe: round(baud * 16 * 2^acc_w / clk_hz).
  function automatic int unsigned calc_baud_inc(input int unsigned baud,
                                                input int unsigned clk_hz,
                                                input int unsigned acc_w);
    longint unsigned num;
    num = (64'(baud) * 64'd16) << acc_w;
    return 32'((num + 64'(clk_hz / 2)) / 64'(clk_hz));
  endfunction

  // 115200 baud x16 from a 50 MHz fabric clock.
  localparam int unsigned IncResetDefault = calc_baud_inc(115200, 50000000, AccWDefault);

endpackage

// File: rtl/abfn_tick_div.sv
// Modulo-N pulse divider: counts enabled cycles, registers a one-cycle tick on wrap.
module abfn_tick_div #(
  parameter int unsigned N = 50
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic wrap_o,
  output logic tick_o
);

  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(N - 1);

  logic [CntW-1:0] cnt_q;
  logic            tick_q;

  // Combinational wrap lets a cascaded divider advance on the same edge this one ticks.
  assign wrap_o = en_i && (cnt_q == CntMax);
  assign tick_o = tick_q;

  // Counter and registered tick.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= wrap_o;
      if (wrap_o) begin
        cnt_q <= '0;
      end else if (en_i) begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/abfn_fab_tick_gen.sv
// Fabric timebase: fractional 16x baud strobe, 1x baud strobe, 1 us and 1 ms strobes.
module abfn_fab_tick_gen
  import abfn_tick_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50000000,
  parameter int unsigned INC_RESET   = IncResetDefault,
  parameter int unsigned ACC_W       = AccWDefault
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             BAUD_EN,
  input  logic             CFG_VALID,
  input  logic [ACC_W-1:0] CFG_INC,
  output logic             CFG_READY,
  output logic             BAUD16_TICK,
  output logic             BAUD_TICK,
  output logic             US_TICK,
  output logic             MS_TICK
);

  localparam int unsigned US_DIV = CLK_FREQ_HZ / 1000000;

  tick_state_e      state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] inc_q, inc_d;
  logic [3:0]       os_cnt_q, os_cnt_d;
  logic             baud16_q, baud16_d;
  logic             baud_q, baud_d;
  logic             ready_q, ready_d;
  logic             accept;
  logic [ACC_W:0]   sum;
  logic             us_wrap;
  logic             ms_wrap_unused;

  assign accept = CFG_VALID && ready_q;
  assign sum    = {1'b0, acc_q} + {1'b0, inc_q};

  assign CFG_READY   = ready_q;
  assign BAUD16_TICK = baud16_q;
  assign BAUD_TICK   = baud_q;

  // Next-state: a config accept overrides every state; otherwise STOP/RUN/LOAD sequencing.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    inc_d    = inc_q;
    os_cnt_d = os_cnt_q;
    baud16_d = 1'b0;
    baud_d   = 1'b0;
    ready_d  = 1'b1;
    if (accept) begin
      state_d  = StLoad;
      inc_d    = CFG_INC;
      acc_d    = '0;
      os_cnt_d = '0;
      ready_d  = 1'b0;
    end else begin
      unique case (state_q)
        StStop: begin
          acc_d    = '0;
          os_cnt_d = '0;
          if (BAUD_EN) state_d = StRun;
        end
        StRun: begin
          if (!BAUD_EN) begin
            state_d  = StStop;
            acc_d    = '0;
            os_cnt_d = '0;
          end else begin
            acc_d    = sum[ACC_W-1:0];
            baud16_d = sum[ACC_W];
            if (sum[ACC_W]) begin
              os_cnt_d = os_cnt_q + 4'd1;
              baud_d   = (os_cnt_q == 4'd15);
            end
          end
        end
        StLoad: begin
          state_d = BAUD_EN ? StRun : StStop;
        end
        default: begin
          state_d = StStop;
        end
      endcase
    end
  end

  // State, accumulator and registered strobes.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      // Enter RUN directly so the accumulator adds on the first edge after release.
      state_q  <= BAUD_EN ? StRun : StStop;
      acc_q    <= '0;
      inc_q    <= ACC_W'(INC_RESET);
      os_cnt_q <= '0;
      baud16_q <= 1'b0;
      baud_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      inc_q    <= inc_d;
      os_cnt_q <= os_cnt_d;
      baud16_q <= baud16_d;
      baud_q   <= baud_d;
      ready_q  <= ready_d;
    end
  end

  abfn_tick_div #(
    .N(US_DIV)
  ) u_us_div (
    .clk_i (CLK),
    .rst_i (RESET),
    .en_i  (1'b1),
    .wrap_o(us_wrap),
    .tick_o(US_TICK)
  );

  // Driven by the us wrap (not US_TICK) so MS_TICK lines up with the wrapping US_TICK.
  abfn_tick_div #(
    .N(1000)
  ) u_ms_div (
    .clk_i (CLK),
    .rst_i (RESET),
    .en_i  (us_wrap),
    .wrap_o(ms_wrap_unused),
    .tick_o(MS_TICK)
  );

endmodule
